sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Sequences all accesses to the shared external SRAM and arbitrates it between the
//  AVR port (read/write) and the SNES port (read-only).
//  Sits between the address source (shift register/counter) and the top-level tristate SRAM pins.
//  Generates ce_n/oe_n/we_n timing with programmable strobe length and write turnaround.
//  Bounds AVR starvation while the SNES has priority.
// PARAMETERS
//  WAIT_CYCLES     2   cycles oe_n/we_n held low per access (>=1)
//  AVR_STARVE_MAX  4   consecutive SNES grants with AVR pending before AVR is forced in (>=1)
// PORTS
//  avr_clk        in   1   system clock, all logic on rising edge
//  avr_reset      in   1   synchronous, active-high reset
//  snes_mode      in   1   1: SNES port enabled; 0: snes_req ignored
//  avr_req        in   1   AVR access request, level, held until avr_ack
//  avr_we         in   1   1: write, 0: read; valid with avr_req
//  avr_addr       in   21  AVR byte address
//  avr_wdata      in   8   AVR write data
//  avr_rdata      out  8   AVR read data, valid while avr_ack=1 and held until next AVR read
//  avr_ack        out  1   one-cycle completion pulse
//  snes_req       in   1   SNES read request, level, held until snes_ack
//  snes_addr      in   21  SNES byte address
//  snes_rdata     out  8   SNES read data, valid while snes_ack=1 and held until next SNES read
//  snes_ack       out  1   one-cycle completion pulse
//  sram_addr      out  21  SRAM address
//  sram_data_o    out  8   SRAM write data
//  sram_data_i    in   8   SRAM read data from pins
//  sram_data_oe   out  1   1: top level drives sram_data_o onto pins
//  sram_ce_n      out  1   chip enable, active low
//  sram_oe_n      out  1   output enable, active low
//  sram_we_n      out  1   write enable, active low
//  busy           out  1   1 in every state except IDLE
// BEHAVIOUR
//  Reset values (next edge with avr_reset=1, including mid-access):
//  - Pins: sram_ce_n/oe_n/we_n=1, sram_data_oe=0, sram_addr=0, sram_data_o=0.
//  - Requester side: avr_rdata=0, snes_rdata=0, avr_ack=0, snes_ack=0, busy=0.
//  - Internal: state=IDLE, starve_cnt=0. An aborted access is never acked.
//  States: IDLE -> SETUP -> STROBE -> HOLD -> (TURN if write) -> IDLE.
//  IDLE: if grant at edge, latch addr/we/wdata and owner, go to SETUP.
//  Grant rule:
//  - SNES wins if snes_mode & snes_req, unless (avr_req & starve_cnt==AVR_STARVE_MAX).
//  - Otherwise AVR wins if avr_req.
//  starve_cnt: +1 on SNES grant with avr_req=1 (saturating); cleared on AVR grant or when avr_req=0.
//  SETUP (1 cyc): ce_n=0, sram_addr driven; on a write, data_oe=1 and data_o=wdata.
//  STROBE (WAIT_CYCLES cyc): ce_n=0; oe_n=0 on a read, we_n=0 on a write.
//  - Read: sram_data_i registered at the edge ending the last STROBE cycle.
//  HOLD (1 cyc): strobes=1, ce_n=0, write data still driven; owner ack=1, rdata valid.
//  TURN (1 cyc, after write only): ce_n=1, data_oe=0; guarantees bus release before any read.
//  Read path: data_oe=0 throughout; oe_n and data_oe never both active.
//  Latency (grant edge = 0): read ack in cycle WAIT_CYCLES+2 (W=2 -> cycle 4).
//  Back-to-back rate: read every WAIT_CYCLES+3 cycles, write every WAIT_CYCLES+4.
//  Handshake: requester drops req in the cycle after ack; a req still high in IDLE is a new access.
//  Address/data are latched at grant, so requester inputs may change during the access.
//  snes_mode falling mid-SNES-access: access completes and acks; later snes_req ignored.
//  avr_req dropped before ack: access completes anyway; ack still pulses.
//  Simultaneous requests in IDLE resolve per grant rule in the same cycle; no idle bubble.
// TESTING
//  1. AVR read @0x4ccf, sram_data_i=0xaa, W=2.
//     -> sram_addr=0x4ccf; oe_n low 2 cyc; avr_ack at cycle 4; avr_rdata=0xaa.
//  2. AVR write 0xee @0x000010.
//     -> data_oe=1 in SETUP..HOLD; we_n low 2 cyc; data_o=0xee; TURN has ce_n=1, data_oe=0.
//  3. avr_req and snes_req rise same cycle, snes_mode=1.
//     -> SNES granted first; AVR granted immediately after SNES HOLD.
//  4. snes_req held high, avr_req high, AVR_STARVE_MAX=4.
//     -> exactly 4 SNES accesses, then 1 AVR, then SNES resumes.
//  5. snes_mode=0, snes_req=1, avr_req=0.
//     -> no access; busy=0; snes_ack never asserts.
//  6. avr_reset=1 during STROBE of a write.
//     -> next edge: we_n=1, ce_n=1, data_oe=0, state IDLE, no ack.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles the requester handshakes and the SRAM pin-side signals of
// sram_arbiter.
//   slave  : arbiter view (requests and sram_data_i in; acks, read data and pins out)
//   master : environment view (requesters plus the tristate pin wrapper)
// AVR port : avr_req/avr_we/avr_addr/avr_wdata in, avr_rdata/avr_ack out
// SNES port: snes_mode/snes_req/snes_addr in, snes_rdata/snes_ack out
// SRAM side: sram_addr/sram_data_o/sram_data_oe/sram_ce_n/sram_oe_n/sram_we_n out,
//            sram_data_i in; busy out
interface sram_arbiter_if;
  logic        snes_mode;
  logic        avr_req;
  logic        avr_we;
  logic [20:0] avr_addr;
  logic [7:0]  avr_wdata;
  logic [7:0]  avr_rdata;
  logic        avr_ack;
  logic        snes_req;
  logic [20:0] snes_addr;
  logic [7:0]  snes_rdata;
  logic        snes_ack;
  logic [20:0] sram_addr;
  logic [7:0]  sram_data_o;
  logic [7:0]  sram_data_i;
  logic        sram_data_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        busy;

  modport slave (
    input  snes_mode, avr_req, avr_we, avr_addr, avr_wdata, snes_req, snes_addr, sram_data_i,
    output avr_rdata, avr_ack, snes_rdata, snes_ack, sram_addr, sram_data_o, sram_data_oe,
           sram_ce_n, sram_oe_n, sram_we_n, busy
  );

  modport master (
    output snes_mode, avr_req, avr_we, avr_addr, avr_wdata, snes_req, snes_addr, sram_data_i,
    input  avr_rdata, avr_ack, snes_rdata, snes_ack, sram_addr, sram_data_o, sram_data_oe,
           sram_ce_n, sram_oe_n, sram_we_n, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences every access to the shared external SRAM and arbitrates it
// between the AVR port (read/write) and the SNES port (read-only). SNES has priority, but
// AVR is forced in after AVR_STARVE_MAX consecutive SNES grants while it waits.
// Access sequence: IDLE -> SETUP -> STROBE (WAIT_CYCLES) -> HOLD -> (TURN on write) -> IDLE.
// All outputs are registered.
// Ports:
//   avr_clk   : system clock, rising edge
//   avr_reset : synchronous active-high reset
//   bus       : sram_arbiter_if.slave (requester handshakes and SRAM pins)
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES    = 2,
  parameter int unsigned AVR_STARVE_MAX = 4
) (
  input logic           avr_clk,
  input logic           avr_reset,
  sram_arbiter_if.slave bus
);

  localparam int unsigned WaitW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned StarveW = $clog2(AVR_STARVE_MAX + 1);
  localparam logic [WaitW-1:0]   WaitLast  = WaitW'(WAIT_CYCLES - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(AVR_STARVE_MAX);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StTurn} state_e;

  state_e               state_q;
  logic [WaitW-1:0]     wait_cnt_q;
  logic [StarveW-1:0]   starve_cnt_q;
  logic                 owner_snes_q;
  logic                 we_q;
  logic [20:0]          addr_q;
  logic [7:0]           data_o_q;
  logic                 data_oe_q;
  logic                 ce_n_q;
  logic                 oe_n_q;
  logic                 we_n_q;
  logic [7:0]           avr_rdata_q;
  logic [7:0]           snes_rdata_q;
  logic                 avr_ack_q;
  logic                 snes_ack_q;
  logic                 busy_q;

  logic avr_forced;
  logic grant_snes;
  logic grant_avr;

  always_comb begin
    avr_forced = bus.avr_req && (starve_cnt_q == StarveMax);
    grant_snes = bus.snes_mode && bus.snes_req && !avr_forced;
    grant_avr  = bus.avr_req && !grant_snes;
  end

  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      owner_snes_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_o_q     <= '0;
      data_oe_q    <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      avr_rdata_q  <= '0;
      snes_rdata_q <= '0;
      avr_ack_q    <= 1'b0;
      snes_ack_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      avr_ack_q  <= 1'b0;
      snes_ack_q <= 1'b0;

      // Starvation counts only SNES grants taken while AVR is actually waiting.
      if (!bus.avr_req) begin
        starve_cnt_q <= '0;
      end else if (state_q == StIdle && grant_snes) begin
        if (starve_cnt_q != StarveMax) starve_cnt_q <= starve_cnt_q + StarveW'(1);
      end else if (state_q == StIdle && grant_avr) begin
        starve_cnt_q <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (grant_snes || grant_avr) begin
            state_q      <= StSetup;
            busy_q       <= 1'b1;
            ce_n_q       <= 1'b0;
            owner_snes_q <= grant_snes;
            if (grant_snes) begin
              addr_q    <= bus.snes_addr;
              we_q      <= 1'b0;
              data_oe_q <= 1'b0;
            end else begin
              addr_q    <= bus.avr_addr;
              we_q      <= bus.avr_we;
              data_oe_q <= bus.avr_we;
              if (bus.avr_we) data_o_q <= bus.avr_wdata;
            end
          end
        end
        StSetup: begin
          state_q    <= StStrobe;
          wait_cnt_q <= '0;
          oe_n_q     <= we_q;
          we_n_q     <= !we_q;
        end
        StStrobe: begin
          if (wait_cnt_q == WaitLast) begin
            state_q <= StHold;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            // oe_n is still low at this edge, so pin data is valid here.
            if (!we_q) begin
              if (owner_snes_q) snes_rdata_q <= bus.sram_data_i;
              else              avr_rdata_q  <= bus.sram_data_i;
            end
            if (owner_snes_q) snes_ack_q <= 1'b1;
            else              avr_ack_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StHold: begin
          ce_n_q <= 1'b1;
          if (we_q) begin
            // Extra cycle so the data bus is released before any following read.
            state_q   <= StTurn;
            data_oe_q <= 1'b0;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StTurn: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sram_addr    = addr_q;
  assign bus.sram_data_o  = data_o_q;
  assign bus.sram_data_oe = data_oe_q;
  assign bus.sram_ce_n    = ce_n_q;
  assign bus.sram_oe_n    = oe_n_q;
  assign bus.sram_we_n    = we_n_q;
  assign bus.avr_rdata    = avr_rdata_q;
  assign bus.snes_rdata   = snes_rdata_q;
  assign bus.avr_ack      = avr_ack_q;
  assign bus.snes_ack     = snes_ack_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against a transaction-level
// model (expected pin waveform per cycle offset from grant, golden memory, grant/starvation
// prediction).
module tb_sram_arbiter;
  localparam int unsigned W  = 2;
  localparam int unsigned SM = 4;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  logic [7:0] pin_mem [0:1023];
  logic [7:0] gold    [0:1023];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  sram_arbiter_if bus ();

  sram_arbiter #(
    .WAIT_CYCLES   (W),
    .AVR_STARVE_MAX(SM)
  ) dut (
    .avr_clk  (clk),
    .avr_reset(rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // SRAM chip model: addresses alias on the low 10 bits.
  assign bus.sram_data_i = (!bus.sram_oe_n && !bus.sram_ce_n) ? pin_mem[bus.sram_addr[9:0]]
                                                             : 8'h00;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) pin_mem[i] <= 8'(i) ^ 8'h65;
    end else if (!bus.sram_we_n && !bus.sram_ce_n && bus.sram_data_oe) begin
      pin_mem[bus.sram_addr[9:0]] <= bus.sram_data_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " ce_n"}, 32'(bus.sram_ce_n), 32'd1);
    check({tag, " data_oe"}, 32'(bus.sram_data_oe), 32'd0);
    check({tag, " avr_ack"}, 32'(bus.avr_ack), 32'd0);
    check({tag, " snes_ack"}, 32'(bus.snes_ack), 32'd0);
  endtask

  // Called in an IDLE cycle whose ending edge is the grant; returns in the last busy cycle.
  task automatic watch_access(input bit snes, input bit we, input logic [20:0] addr,
                              input logic [7:0] wdata);
    int   last;
    bit   strobe;
    bit   hold;
    logic [7:0] exp_rd;
    string who;
    who    = snes ? "snes" : "avr";
    last   = we ? W + 3 : W + 2;
    exp_rd = gold[addr[9:0]];
    if (we) gold[addr[9:0]] = wdata;
    for (int k = 1; k <= last; k++) begin
      step();
      strobe = (k >= 2) && (k <= W + 1);
      hold   = (k == W + 2);
      check($sformatf("%s busy k%0d", who, k), 32'(bus.busy), 32'd1);
      check($sformatf("%s ce_n k%0d", who, k), 32'(bus.sram_ce_n), 32'(k > W + 2));
      check($sformatf("%s oe_n k%0d", who, k), 32'(bus.sram_oe_n), 32'(!(strobe && !we)));
      check($sformatf("%s we_n k%0d", who, k), 32'(bus.sram_we_n), 32'(!(strobe && we)));
      check($sformatf("%s data_oe k%0d", who, k), 32'(bus.sram_data_oe), 32'(we && k <= W + 2));
      check($sformatf("%s avr_ack k%0d", who, k), 32'(bus.avr_ack), 32'(!snes && hold));
      check($sformatf("%s snes_ack k%0d", who, k), 32'(bus.snes_ack), 32'(snes && hold));
      if (k <= W + 2) check($sformatf("%s addr k%0d", who, k), 32'(bus.sram_addr), 32'(addr));
      if (we && k <= W + 2)
        check($sformatf("%s data_o k%0d", who, k), 32'(bus.sram_data_o), 32'(wdata));
      if (hold && !we) begin
        if (snes) check("snes rdata", 32'(bus.snes_rdata), 32'(exp_rd));
        else      check("avr rdata", 32'(bus.avr_rdata), 32'(exp_rd));
      end
    end
  endtask

  initial begin
    bit snes_wins;
    bit avr_pend;
    bit snes_pend;
    int unsigned streak;

    for (int i = 0; i < 1024; i++) gold[i] = 8'(i) ^ 8'h65;
    rst = 1'b1;
    mem_init = 1'b1;
    bus.snes_mode = 1'b1;
    bus.avr_req = 1'b0;
    bus.avr_we = 1'b0;
    bus.avr_addr = '0;
    bus.avr_wdata = '0;
    bus.snes_req = 1'b0;
    bus.snes_addr = '0;
    step();
    step();
    check("rst sram_addr", 32'(bus.sram_addr), 32'd0);
    check("rst data_o", 32'(bus.sram_data_o), 32'd0);
    check("rst oe_n", 32'(bus.sram_oe_n), 32'd1);
    check("rst we_n", 32'(bus.sram_we_n), 32'd1);
    check("rst avr_rdata", 32'(bus.avr_rdata), 32'd0);
    check("rst snes_rdata", 32'(bus.snes_rdata), 32'd0);
    idle_check("rst");
    rst = 1'b0;
    mem_init = 1'b0;
    step();

    // 1: AVR read @0x4ccf, pin data 0xaa.
    bus.avr_req = 1'b1; bus.avr_we = 1'b0; bus.avr_addr = 21'h4ccf;
    watch_access(1'b0, 1'b0, 21'h4ccf, 8'h00);
    check("t1 avr_rdata", 32'(bus.avr_rdata), 32'haa);
    step(); bus.avr_req = 1'b0; idle_check("t1 idle");

    // 2: AVR write 0xee @0x10, then read it back.
    bus.avr_req = 1'b1; bus.avr_we = 1'b1; bus.avr_addr = 21'h10; bus.avr_wdata = 8'hee;
    watch_access(1'b0, 1'b1, 21'h10, 8'hee);
    step(); bus.avr_req = 1'b0; idle_check("t2 idle");
    bus.avr_req = 1'b1; bus.avr_we = 1'b0; bus.avr_addr = 21'h10;
    watch_access(1'b0, 1'b0, 21'h10, 8'h00);
    step(); bus.avr_req = 1'b0; idle_check("t2b idle");

    // 3: simultaneous requests: SNES first, then AVR right after.
    bus.avr_req = 1'b1; bus.avr_we = 1'b0; bus.avr_addr = 21'h123;
    bus.snes_req = 1'b1; bus.snes_addr = 21'h1f0345;
    watch_access(1'b1, 1'b0, 21'h1f0345, 8'h00);
    step(); bus.snes_req = 1'b0; idle_check("t3 idle");
    watch_access(1'b0, 1'b0, 21'h123, 8'h00);
    step(); bus.avr_req = 1'b0; idle_check("t3b idle");

    // 4: starvation bound: 4 SNES, 1 AVR, SNES resumes.
    bus.avr_req = 1'b1; bus.avr_we = 1'b0; bus.avr_addr = 21'h0a5;
    bus.snes_req = 1'b1;
    for (int i = 0; i < int'(SM); i++) begin
      bus.snes_addr = 21'($urandom);
      watch_access(1'b1, 1'b0, bus.snes_addr, 8'h00);
      step(); idle_check("t4 idle");
    end
    watch_access(1'b0, 1'b0, 21'h0a5, 8'h00);
    step(); bus.avr_req = 1'b0; idle_check("t4 avr idle");
    watch_access(1'b1, 1'b0, bus.snes_addr, 8'h00);
    step(); bus.snes_req = 1'b0; idle_check("t4 end idle");

    // 5: snes_mode=0 ignores snes_req.
    bus.snes_mode = 1'b0; bus.snes_req = 1'b1;
    for (int i = 0; i < 8; i++) begin step(); idle_check("t5"); end
    bus.snes_req = 1'b0; bus.snes_mode = 1'b1;
    step();

    // 6: reset during STROBE of a write aborts without ack.
    bus.avr_req = 1'b1; bus.avr_we = 1'b1; bus.avr_addr = 21'h222; bus.avr_wdata = 8'h77;
    step();
    step();
    check("t6 setup data_oe", 32'(bus.sram_data_oe), 32'd1);
    step();
    check("t6 strobe we_n", 32'(bus.sram_we_n), 32'd0);
    rst = 1'b1; bus.avr_req = 1'b0;
    step();
    // The aborted strobe still wrote the cell.
    gold[10'h222] = 8'h77;
    rst = 1'b0;
    check("t6 we_n", 32'(bus.sram_we_n), 32'd1);
    check("t6 oe_n", 32'(bus.sram_oe_n), 32'd1);
    check("t6 sram_addr", 32'(bus.sram_addr), 32'd0);
    check("t6 avr_rdata", 32'(bus.avr_rdata), 32'd0);
    idle_check("t6 rst");
    for (int i = 0; i < 6; i++) begin step(); idle_check("t6 after"); end

    // Randomized contention with predicted grant order.
    avr_pend = 1'b0; snes_pend = 1'b0; streak = 0;
    for (int r = 0; r < 40; r++) begin
      if (!avr_pend && $urandom_range(0, 2) != 0) begin
        avr_pend = 1'b1; bus.avr_req = 1'b1; bus.avr_we = 1'($urandom_range(0, 1));
        bus.avr_addr = 21'($urandom); bus.avr_wdata = 8'($urandom);
      end
      if (!snes_pend && ($urandom_range(0, 3) != 0 || !avr_pend)) begin
        snes_pend = 1'b1; bus.snes_req = 1'b1; bus.snes_addr = 21'($urandom);
      end
      snes_wins = snes_pend && !(avr_pend && streak == SM);
      if (avr_pend && snes_wins) streak = (streak < SM) ? streak + 1 : streak;
      else streak = 0;
      if (snes_wins) watch_access(1'b1, 1'b0, bus.snes_addr, 8'h00);
      else watch_access(1'b0, bus.avr_we, bus.avr_addr, bus.avr_wdata);
      step();
      if (snes_wins) begin snes_pend = 1'b0; bus.snes_req = 1'b0; end
      else begin avr_pend = 1'b0; bus.avr_req = 1'b0; end
      idle_check($sformatf("rnd%0d idle", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
